// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds opcode/funct constants, 4-bit ALU operation codes, the datapath
// select encodings (PCSrc, ALUSrcB), the controller state enum and the
// instruction class produced by the decoder.
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes (low 4 bits of ALUCntl)
    localparam logic [3:0] ALU_ADD  = 4'b1010;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1110;
    localparam logic [3:0] ALU_SUBU = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // PCSrc encodings
    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// alu_decode: combinational instruction decoder shared by the DECODE and
// EXEC states of the multicycle controller.
// Ports:
//   op, func    - opcode and funct fields from the instruction register
//   aluCode     - 4-bit ALU operation for the instruction's execute step
//   instrClass  - instruction class used to route the DECODE state
//   legal       - 1 when the opcode (and funct for R-type) is supported
module alu_decode
    import mips_ctrl_pkg::*;
#(
    parameter int SUPPORT_JUMP = 1
) (
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output logic [3:0]   aluCode,
    output instr_class_t instrClass,
    output logic         legal
);

    always_comb begin
        aluCode    = ALU_ADD;
        instrClass = CLS_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                instrClass = CLS_ALU_R;
                case (func)
                    FN_ADD:  aluCode = ALU_ADD;
                    FN_ADDU: aluCode = ALU_ADDU;
                    FN_SUB:  aluCode = ALU_SUB;
                    FN_SUBU: aluCode = ALU_SUBU;
                    FN_AND:  aluCode = ALU_AND;
                    FN_OR:   aluCode = ALU_OR;
                    FN_XOR:  aluCode = ALU_XOR;
                    FN_NOR:  aluCode = ALU_NOR;
                    FN_SLT:  aluCode = ALU_SLT;
                    FN_SLTU: aluCode = ALU_SLTU;
                    default: instrClass = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin instrClass = CLS_ALU_I; aluCode = ALU_ADD;  end
            OP_ADDIU: begin instrClass = CLS_ALU_I; aluCode = ALU_ADDU; end
            OP_ANDI:  begin instrClass = CLS_ALU_I; aluCode = ALU_AND;  end
            OP_ORI:   begin instrClass = CLS_ALU_I; aluCode = ALU_OR;   end
            OP_SLTI:  begin instrClass = CLS_ALU_I; aluCode = ALU_SLT;  end
            OP_SLTIU: begin instrClass = CLS_ALU_I; aluCode = ALU_SLTU; end
            // Address generation is an unsigned add of base + offset.
            OP_LW, OP_SW:   begin instrClass = CLS_MEM;    aluCode = ALU_ADDU; end
            OP_BEQ, OP_BNE: begin instrClass = CLS_BRANCH; aluCode = ALU_SUB;  end
            OP_J: begin
                if (SUPPORT_JUMP != 0) instrClass = CLS_JUMP;
            end
            default: instrClass = CLS_ILLEGAL;
        endcase
    end

    assign legal = (instrClass != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the shared datapath enables one state at a time.
// Ports:
//   clk, reset           - rising-edge clock, async active-high reset
//   Op, Func, Zero       - instruction fields and ALU zero flag
//   mem_ready / mem_req  - memory handshake: mem_req is held high for the
//                          whole access; the access completes in the cycle
//                          mem_ready is sampled high while mem_req is high.
//                          A request waiting WAIT_MAX cycles without
//                          mem_ready raises mem_fault and halts.
//   MemRead .. MemtoReg  - datapath controls (Moore decode of state)
//   illegal, mem_fault   - sticky trap flags, cleared only by reset
//   dbgState             - current FSM state for observation
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CNTL_W   = 4,
    parameter int WAIT_MAX     = 15,
    parameter int SUPPORT_JUMP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Op,
    input  logic [5:0]            Func,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IorD,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic [1:0]            PCSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CNTL_W-1:0] ALUCntl,
    output logic                  RegWrite,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  illegal,
    output logic                  mem_fault,
    output state_t                dbgState
);

    // The counter holds the number of wait cycles already spent; the cycle
    // in which it equals WAIT_MAX-1 is the WAIT_MAX-th wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t       state;
    logic [7:0]   waitCnt;
    logic         memPhase;
    logic [3:0]   decCode;
    instr_class_t decClass;
    logic         decLegal;
    logic [3:0]   aluCode;

    alu_decode #(
        .SUPPORT_JUMP(SUPPORT_JUMP)
    ) u_alu_decode (
        .op        (Op),
        .func      (Func),
        .aluCode   (decCode),
        .instrClass(decClass),
        .legal     (decLegal)
    );

    assign memPhase = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign dbgState = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            waitCnt   <= '0;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else if (memPhase && !mem_ready) begin
            // Stalled memory access: count, or give up at the limit.
            if (waitCnt == WAIT_LAST) begin
                mem_fault <= 1'b1;
                waitCnt   <= '0;
                state     <= S_HALT;
            end else begin
                waitCnt <= waitCnt + 8'd1;
            end
        end else begin
            waitCnt <= '0;
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (!decLegal) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        case (decClass)
                            CLS_ALU_R:  state <= S_EXEC_R;
                            CLS_ALU_I:  state <= S_EXEC_I;
                            CLS_MEM:    state <= S_MEM_ADDR;
                            CLS_BRANCH: state <= S_BRANCH;
                            CLS_JUMP:   state <= S_JUMP;
                            default: begin
                                illegal <= 1'b1;
                                state   <= S_HALT;
                            end
                        endcase
                    end
                end
                S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
                S_MEM_ADDR: state <= (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state <= S_WB_MEM;
                S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_HALT;
            endcase
        end
    end

    // Output decode. Gated by reset so a request in flight drops the
    // moment reset rises, without waiting for a clock edge.
    always_comb begin
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PCSRC_PC4;
        ALUSrcA  = 1'b0;
        ALUSrcB  = ALUB_RT;
        aluCode  = ALU_AND;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = ALUB_FOUR;
                    aluCode = ALU_ADD;
                    // IR and PC+4 load only when the fetch completes.
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = ALUB_IMM_SH;
                    aluCode = ALU_ADD;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUB_RT;
                    aluCode = decCode;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUB_IMM;
                    aluCode = decCode;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    RegDst   = (Op == OP_RTYPE);
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUB_IMM;
                    aluCode = ALU_ADDU;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUB_RT;
                    aluCode = ALU_SUB;
                    PCSrc   = PCSRC_BRANCH;
                    PCWrite = (Op == OP_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALUCntl = ALU_CNTL_W'(aluCode);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (defaults, and WAIT_MAX=4 /
// no jump / 6-bit ALUCntl) share all inputs. Expected per-cycle controls
// come from a behavioural model that expands an instruction into its
// cycle list from the opcode tables and memory wait counts.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = '0;
    logic [5:0] Func = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic       mem_req_0, mem_read_0, mem_write_0, iord_0, ir_write_0, pc_write_0;
    logic [1:0] pc_src_0, alu_src_b_0;
    logic       alu_src_a_0, reg_write_0, reg_dst_0, memto_reg_0, illegal_0, mem_fault_0;
    logic [3:0] alu_cntl_0;
    state_t     dbg_state_0;

    logic       mem_req_1, mem_read_1, mem_write_1, iord_1, ir_write_1, pc_write_1;
    logic [1:0] pc_src_1, alu_src_b_1;
    logic       alu_src_a_1, reg_write_1, reg_dst_1, memto_reg_1, illegal_1, mem_fault_1;
    logic [5:0] alu_cntl_1;
    state_t     dbg_state_1;

    multicycle_control dut0 (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req_0), .MemRead(mem_read_0), .MemWrite(mem_write_0), .IorD(iord_0),
        .IRWrite(ir_write_0), .PCWrite(pc_write_0), .PCSrc(pc_src_0), .ALUSrcA(alu_src_a_0),
        .ALUSrcB(alu_src_b_0), .ALUCntl(alu_cntl_0), .RegWrite(reg_write_0), .RegDst(reg_dst_0),
        .MemtoReg(memto_reg_0), .illegal(illegal_0), .mem_fault(mem_fault_0), .dbgState(dbg_state_0)
    );

    multicycle_control #(.ALU_CNTL_W(6), .WAIT_MAX(4), .SUPPORT_JUMP(0)) dut1 (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req_1), .MemRead(mem_read_1), .MemWrite(mem_write_1), .IorD(iord_1),
        .IRWrite(ir_write_1), .PCWrite(pc_write_1), .PCSrc(pc_src_1), .ALUSrcA(alu_src_a_1),
        .ALUSrcB(alu_src_b_1), .ALUCntl(alu_cntl_1), .RegWrite(reg_write_1), .RegDst(reg_dst_1),
        .MemtoReg(memto_reg_1), .illegal(illegal_1), .mem_fault(mem_fault_1), .dbgState(dbg_state_1)
    );

    // ---------------- control vector ----------------
    typedef struct packed {
        logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu;
        logic       reg_write, reg_dst, memto_reg, illegal, mem_fault;
    } ctl_t;
    localparam int CTL_W = $bits(ctl_t);

    ctl_t act_0, act_1;
    assign act_0 = {mem_req_0, mem_read_0, mem_write_0, iord_0, ir_write_0, pc_write_0, pc_src_0,
                    alu_src_a_0, alu_src_b_0, alu_cntl_0, reg_write_0, reg_dst_0, memto_reg_0,
                    illegal_0, mem_fault_0};
    assign act_1 = {mem_req_1, mem_read_1, mem_write_1, iord_1, ir_write_1, pc_write_1, pc_src_1,
                    alu_src_a_1, alu_src_b_1, alu_cntl_1[3:0], reg_write_1, reg_dst_1, memto_reg_1,
                    illegal_1, mem_fault_1};

    // ---------------- scoreboard ----------------
    logic [CTL_W-1:0] exp_q[$];
    logic             rdy_q[$];
    bit               m_illegal, m_fault;
    int               n_compared = 0;
    int               n_mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CTL_W-1:0] act_of(input int which);
        return (which != 0) ? act_1 : act_0;
    endfunction

    function automatic state_t state_of(input int which);
        return (which != 0) ? dbg_state_1 : dbg_state_0;
    endfunction

    // ---------------- reference model ----------------
    logic [5:0] r_func[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [3:0] r_code[10] = '{4'b1010, 4'b0010, 4'b1110, 4'b0110, 4'b0000,
                               4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b1111};
    logic [5:0] i_op[6]    = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
    logic [3:0] i_code[6]  = '{4'b1010, 4'b0010, 4'b0000, 4'b0001, 4'b0101, 4'b1111};

    task automatic push(input ctl_t c, input logic rdy);
        c.illegal   = m_illegal;
        c.mem_fault = m_fault;
        exp_q.push_back(c);
        rdy_q.push_back(rdy);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // kind: 0 = instruction fetch, 1 = data read, 2 = data write
    task automatic model_access(input int d, input int wm, input int kind, output bit ok);
        ctl_t c = '0;
        c.mem_req   = 1'b1;
        c.mem_read  = (kind != 2);
        c.mem_write = (kind == 2);
        c.iord      = (kind != 0);
        if (kind == 0) begin
            c.alu_src_b = 2'b01;
            c.alu       = 4'b1010;
        end
        for (int i = 0; i < d && i < wm; i++) push(c, 1'b0);
        if (d >= wm) begin
            m_fault = 1'b1;
            ok = 1'b0;
            return;
        end
        if (kind == 0) begin
            c.ir_write = 1'b1;
            c.pc_write = 1'b1;
        end
        push(c, 1'b1);
        ok = 1'b1;
    endtask

    task automatic model_instr(input logic [5:0] op, input logic [5:0] func, input logic z,
                               input int d_f, input int d_m, input int wm, input bit jump_ok);
        ctl_t c;
        bit   ok;
        int   k_r = -1;
        int   k_i = -1;
        model_access(d_f, wm, 0, ok);
        if (!ok) return;
        c = '0; c.alu_src_b = 2'b11; c.alu = 4'b1010;
        push(c, rnd_bit());
        for (int i = 0; i < 10; i++) if (op == 6'h00 && func == r_func[i]) k_r = i;
        for (int i = 0; i < 6; i++)  if (op == i_op[i]) k_i = i;
        if (k_r >= 0) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu = r_code[k_r];
            push(c, rnd_bit());
            c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
            push(c, rnd_bit());
        end else if (k_i >= 0) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu = i_code[k_i];
            push(c, rnd_bit());
            c = '0; c.reg_write = 1'b1;
            push(c, rnd_bit());
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu = 4'b0010;
            push(c, rnd_bit());
            model_access(d_m, wm, (op == 6'h23) ? 1 : 2, ok);
            if (!ok) return;
            if (op == 6'h23) begin
                c = '0; c.reg_write = 1'b1; c.memto_reg = 1'b1;
                push(c, rnd_bit());
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu = 4'b1110;
            c.pc_src = 2'b01; c.pc_write = (op == 6'h04) ? z : ~z;
            push(c, rnd_bit());
        end else if (op == 6'h02 && jump_ok) begin
            c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1;
            push(c, rnd_bit());
        end else begin
            m_illegal = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        m_illegal = 1'b0;
        m_fault = 1'b0;
        mem_ready = rnd_bit();
        @(negedge clk);
        check("reset_ctl0", 32'(act_0), 32'd0);
        check("reset_ctl1", 32'({act_1, alu_cntl_1[5:4]}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state0", 32'(dbg_state_0), 32'(S_FETCH));
    endtask

    // Plays the model's queue against one DUT until it returns to fetch
    // or halts; returns the measured instruction length in cycles.
    task automatic play(input int which, input string tag, output int lat, output bit halted);
        state_t prev, now;
        bit     done = 1'b0;
        int     model_len = exp_q.size();
        logic [CTL_W-1:0] e;
        lat = 0;
        now = state_of(which);
        for (int c = 0; c < 60 && !done; c++) begin
            mem_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : rnd_bit();
            @(negedge clk);
            prev = state_of(which);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s cyc%0d", tag, c), 32'(act_of(which)), 32'(e));
                if (which != 0) check($sformatf("%s alu_hi cyc%0d", tag, c), 32'(alu_cntl_1[5:4]), 32'd0);
            end
            @(posedge clk);
            #1;
            now = state_of(which);
            lat = c + 1;
            done = (now == S_HALT) || (now == S_FETCH && prev != S_FETCH);
        end
        check($sformatf("%s done", tag), 32'(done), 32'd1);
        check($sformatf("%s model_len", tag), 32'(lat), 32'(model_len));
        halted = (now == S_HALT);
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic halt_hold(input int which, input string tag);
        ctl_t h;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rnd_bit();
            Op = 6'($urandom);
            @(negedge clk);
            h = '0; h.illegal = m_illegal; h.mem_fault = m_fault;
            check($sformatf("%s halt%0d", tag, i), 32'(act_of(which)), 32'(h));
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        int         d_f;
        int         d_m;
        int         which;
        int         lat;
        bit         end_halt;
    } vec_t;
    vec_t vecs[$];

    initial begin
        int  lat;
        bit  halted;
        bit  need_reset;
        int  last_which;
        logic [5:0] op_pool[13];

        vecs.push_back('{6'h00, 6'h20, 1'b0, 0,  0, 0, 4,  1'b0});  // add
        vecs.push_back('{6'h00, 6'h22, 1'b0, 1,  0, 0, 5,  1'b0});  // sub
        vecs.push_back('{6'h00, 6'h27, 1'b0, 0,  0, 0, 4,  1'b0});  // nor
        vecs.push_back('{6'h00, 6'h2B, 1'b0, 2,  0, 0, 6,  1'b0});  // sltu
        vecs.push_back('{6'h00, 6'h26, 1'b1, 0,  0, 0, 4,  1'b0});  // xor
        vecs.push_back('{6'h08, 6'h00, 1'b0, 0,  0, 0, 4,  1'b0});  // addi
        vecs.push_back('{6'h0D, 6'h00, 1'b0, 1,  0, 0, 5,  1'b0});  // ori
        vecs.push_back('{6'h0A, 6'h00, 1'b0, 0,  0, 0, 4,  1'b0});  // slti
        vecs.push_back('{6'h23, 6'h00, 1'b0, 3,  3, 0, 11, 1'b0});  // lw, 3 waits twice
        vecs.push_back('{6'h2B, 6'h00, 1'b0, 0,  2, 0, 6,  1'b0});  // sw
        vecs.push_back('{6'h04, 6'h00, 1'b1, 0,  0, 0, 3,  1'b0});  // beq taken
        vecs.push_back('{6'h04, 6'h00, 1'b0, 0,  0, 0, 3,  1'b0});  // beq not taken
        vecs.push_back('{6'h05, 6'h00, 1'b1, 0,  0, 0, 3,  1'b0});  // bne, Zero=1
        vecs.push_back('{6'h05, 6'h00, 1'b0, 1,  0, 0, 4,  1'b0});  // bne taken
        vecs.push_back('{6'h02, 6'h00, 1'b0, 0,  0, 0, 3,  1'b0});  // j
        vecs.push_back('{6'h3F, 6'h00, 1'b0, 0,  0, 0, 2,  1'b1});  // illegal op
        vecs.push_back('{6'h00, 6'h3F, 1'b0, 0,  0, 0, 2,  1'b1});  // illegal funct
        vecs.push_back('{6'h00, 6'h20, 1'b0, 14, 0, 0, 18, 1'b0});  // ready on last allowed cycle
        vecs.push_back('{6'h00, 6'h20, 1'b0, 15, 0, 0, 15, 1'b1});  // fetch timeout
        vecs.push_back('{6'h00, 6'h20, 1'b0, 10, 0, 1, 4,  1'b1});  // WAIT_MAX=4 fault
        vecs.push_back('{6'h00, 6'h20, 1'b0, 3,  0, 1, 7,  1'b0});  // ready on 4th cycle
        vecs.push_back('{6'h02, 6'h00, 1'b0, 0,  0, 1, 2,  1'b1});  // j unsupported
        vecs.push_back('{6'h23, 6'h00, 1'b0, 0,  5, 1, 7,  1'b1});  // MEM_RD timeout
        vecs.push_back('{6'h2B, 6'h00, 1'b0, 0,  3, 1, 7,  1'b0});  // sw, 3 waits

        @(posedge clk);
        #1;
        do_reset();
        last_which = 0;
        need_reset = 1'b0;

        foreach (vecs[i]) begin
            if (need_reset || vecs[i].which != last_which) do_reset();
            last_which = vecs[i].which;
            Op = vecs[i].op; Func = vecs[i].func; Zero = vecs[i].z;
            model_instr(vecs[i].op, vecs[i].func, vecs[i].z, vecs[i].d_f, vecs[i].d_m,
                        (vecs[i].which != 0) ? 4 : 15, vecs[i].which == 0);
            play(vecs[i].which, $sformatf("vec%0d", i), lat, halted);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].end_halt));
            if (halted) halt_hold(vecs[i].which, $sformatf("vec%0d", i));
            need_reset = halted;
        end

        // Reset asserted mid-write: request must drop with no clock edge.
        do_reset();
        Op = 6'h2B; Func = 6'h00;
        mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = rnd_bit();
        @(posedge clk); #1 mem_ready = rnd_bit();
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        check("mw_req_before", 32'({mem_req_0, mem_write_0, iord_0}), 32'b111);
        #2 reset = 1'b1;
        #1;
        check("mw_req_async_drop", 32'({mem_req_0, mem_write_0, iord_0}), 32'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mw_state_after", 32'(dbg_state_0), 32'(S_FETCH));
        check("mw_fetch_req", 32'({mem_req_0, mem_read_0, mem_write_0}), 32'b110);
        @(posedge clk);
        #1;

        // Randomized instruction stream on the default instance.
        op_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B,
                    6'h23, 6'h2B, 6'h04, 6'h02};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op, fn;
            int d_f, d_m;
            op = op_pool[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            if (op == 6'h04 && rnd_bit()) op = 6'h05;
            fn = r_func[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            d_f = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 4);
            d_m = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 4);
            Op = op; Func = fn; Zero = rnd_bit();
            model_instr(op, fn, Zero, d_f, d_m, 15, 1'b1);
            play(0, $sformatf("rnd%0d", n), lat, halted);
            if (halted) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives datapath enables one state at a time. It generalises the single-cycle decoder with a parametrised ALU control width, a memory ready/request handshake with a timeout, jump support and illegal-opcode trapping. It sits between the instruction register (Op/Func) and the shared multicycle datapath.

Parameters:
ALU_CNTL_W, 4, width of ALUCntl output
WAIT_MAX, 15, max cycles a memory access may wait for mem_ready before fault; 1..255
SUPPORT_JUMP, 1, 1 = opcode 0x02 (j) legal; 0 = treated as illegal

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Op  input  6  opcode from instruction register
Func  input  6  funct field from instruction register
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request, held until mem_ready
MemRead  output  1  read request qualifier
MemWrite  output  1  write request qualifier
IorD  output  1  0 = PC address, 1 = ALUOut address
IRWrite  output  1  load instruction register
PCWrite  output  1  PC load enable
PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target
ALUSrcA  output  1  0 = PC, 1 = rs
ALUSrcB  output  2  00 rt, 01 const 4, 10 SE imm, 11 SE imm<<2
ALUCntl  output  ALU_CNTL_W  ALU operation; codes in low 4 bits, upper bits zero
RegWrite  output  1  register file write enable
RegDst  output  1  1 = rd, 0 = rt
MemtoReg  output  1  1 = MDR, 0 = ALUOut
illegal  output  1  sticky: unsupported opcode or funct decoded
mem_fault  output  1  sticky: memory wait exceeded WAIT_MAX

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT. Registered state; outputs are a Moore decode of state, except PCWrite in BRANCH, which also depends on Zero.
- Reset (async): state = FETCH, wait counter = 0, illegal = 0, mem_fault = 0. All datapath enables deassert while reset is high.
- FETCH: mem_req = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUCntl = add (1010). IRWrite and PCWrite (PCSrc = 00) pulse only in the cycle mem_ready = 1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUCntl = add (branch target precompute). Next state:
  - Op 0 with legal Func -> EXEC_R
  - 08/09/0C/0D/0A/0B -> EXEC_I
  - 23/2B -> MEM_ADDR
  - 04/05 -> BRANCH
  - 02 with SUPPORT_JUMP -> JUMP
  - else set illegal, -> HALT
- ALU codes:
  - add 1010, addu 0010, sub 1110, subu 0110, and 0000, or 0001, xor 0011, nor 1100, slt 0101, sltu 1111
  - R-type Func 20..27, 2A, 2B map in that order. Immediates 08 add, 09 addu, 0C and, 0D or, 0A slt, 0B sltu.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUCntl from Func -> WB_ALU with RegDst = 1.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10 -> WB_ALU with RegDst = 0.
- WB_ALU: RegWrite = 1, MemtoReg = 0, 1 cycle -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, addu. Op 23 -> MEM_RD, Op 2B -> MEM_WR.
- MEM_RD / MEM_WR: IorD = 1, mem_req = 1, MemRead or MemWrite = 1, held until mem_ready. Then MEM_RD -> WB_MEM and MEM_WR -> FETCH.
- WB_MEM: RegWrite = 1, RegDst = 0, MemtoReg = 1 -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, sub, PCSrc = 01. PCWrite = Zero for 04, ~Zero for 05. -> FETCH.
- JUMP: PCSrc = 10, PCWrite = 1 -> FETCH.
- Minimum latencies with mem_ready = 1: R/I = 4 cycles, lw = 5, sw = 4, branch/jump = 3.
- Wait counter:
  - Increments each cycle mem_req = 1 and mem_ready = 0; clears on mem_ready or on leaving the state.
  - When the count reaches WAIT_MAX with mem_ready still low, set mem_fault and go to HALT.
  - mem_ready in the same cycle the count hits WAIT_MAX completes normally; no fault.
- HALT: all enables 0, mem_req = 0. Remains until reset.
- Reset asserted mid-access drops mem_req immediately (async).

Decomposition:
- Shared package mips_ctrl_pkg: opcode and funct constants, ALU code constants, state enum, PCSrc/ALUSrcB encodings.
- One sub-module, alu_decode: combinational Op/Func -> ALUCntl plus a legal flag. It is reused in DECODE and in the EXEC states.

Test Plan:
- add R-type (Op 00, Func 20), mem_ready = 1 always -> FETCH, DECODE, EXEC_R (ALUCntl 1010), WB_ALU (RegWrite = 1, RegDst = 1); back in FETCH at cycle 4.
- lw (Op 23) with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held 4 cycles each; WB_MEM has MemtoReg = 1; total 11 cycles.
- beq (Op 04) Zero = 1 -> PCWrite = 1, PCSrc = 01 in BRANCH. bne (Op 05) Zero = 1 -> PCWrite = 0.
- Op 3F, and Op 00 with Func 3F -> illegal = 1, HALT, all enables 0 until reset.
- WAIT_MAX = 4, mem_ready low forever in FETCH -> mem_fault = 1 after 4 wait cycles. Repeat with mem_ready on the 4th cycle -> no fault.
- Reset asserted during MEM_WR -> mem_req and MemWrite drop the same cycle; state FETCH after release; SUPPORT_JUMP = 0 with Op 02 -> illegal.
